// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
// Widths and reset half-period defaults live here so the bank, channel and bench agree.
package clk_div_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DEF_HP_DEF = 1;
  // A half-period of zero parks a channel with its output held low.
  localparam int HP_OFF     = 0;

  function automatic int unsigned half_period(input int unsigned ratio);
    return ratio / 2;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle of the divider bank: realign, cascade select, config port and outputs.
// The master side drives realign and config; the slave side is the bank itself.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              sync_rst;
  logic [NUM_CH-1:0] cascade;
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_hp;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] cfg_pending;

  modport master (
    output sync_rst, cascade, cfg_wr, cfg_ch, cfg_hp,
    input  clk_out, rise, cfg_pending
  );

  modport slave (
    input  sync_rst, cascade, cfg_wr, cfg_ch, cfg_hp,
    output clk_out, rise, cfg_pending
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counts advance events, toggles a 50%-duty output every act_hp events
// and swaps in a pending half-period only when a full period has completed.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEF_HP = DEF_HP_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             sync_rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] hp,
  output logic             clk_out,
  output logic             rise,
  output logic             pending
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HP_DIS = CNT_W'(HP_OFF);
  localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEF_HP);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] act_hp_reg, act_hp_next;
  logic [CNT_W-1:0] pend_hp_reg, pend_hp_next;
  logic             pend_v_reg, pend_v_next;
  logic             clk_reg, clk_next;
  logic             rise_reg, rise_next;
  logic             apply;
  logic [CNT_W-1:0] hp_m1;

  assign hp_m1 = act_hp_reg - ONE;

  always_comb begin
    cnt_next     = cnt_reg;
    act_hp_next  = act_hp_reg;
    pend_hp_next = pend_hp_reg;
    pend_v_next  = pend_v_reg;
    clk_next     = clk_reg;
    rise_next    = 1'b0;
    apply        = 1'b0;

    if (sync_rst) begin
      cnt_next = '0;
      clk_next = 1'b0;
      apply    = pend_v_reg;
    end else if (act_hp_reg == HP_DIS) begin
      cnt_next = '0;
      clk_next = 1'b0;
      apply    = pend_v_reg;
    end else if (adv) begin
      if (cnt_reg == hp_m1) begin
        cnt_next  = '0;
        clk_next  = ~clk_reg;
        rise_next = ~clk_reg;
        // Only the falling toggle closes a period, so ratio swaps never cut a pulse short.
        apply     = clk_reg & pend_v_reg;
      end else begin
        cnt_next = cnt_reg + ONE;
      end
    end

    if (apply) begin
      act_hp_next = pend_hp_reg;
      pend_v_next = 1'b0;
    end
    // A write landing with an apply stays pending: the old value is consumed first.
    if (wr) begin
      pend_hp_next = hp;
      pend_v_next  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      act_hp_reg  <= HP_RST;
      pend_hp_reg <= '0;
      pend_v_reg  <= 1'b0;
      clk_reg     <= 1'b0;
      rise_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      act_hp_reg  <= act_hp_next;
      pend_hp_reg <= pend_hp_next;
      pend_v_reg  <= pend_v_next;
      clk_reg     <= clk_next;
      rise_reg    <= rise_next;
    end
  end

  assign clk_out = clk_reg;
  assign rise    = rise_reg;
  assign pending = pend_v_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH synchronous dividers; each channel counts sys_clk or the registered rise
// pulse of the channel below it, giving one cycle of lag per cascade stage.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEF_HP = DEF_HP_DEF
) (
  input  logic          sys_clk,
  input  logic          reset,
  clk_div_bank_if.slave bus
);

  logic [NUM_CH-1:0] clk_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] adv_w;
  logic [NUM_CH-1:0] wr_dec;
  logic              unused_cascade0;

  // Channel 0 has nothing below it, so its cascade bit carries no meaning.
  assign unused_cascade0 = bus.cascade[0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    if (gi == 0) begin : g_base
      assign adv_w[gi] = 1'b1;
    end else begin : g_casc
      assign adv_w[gi] = bus.cascade[gi] ? rise_w[gi-1] : 1'b1;
    end

    // Indices at or above NUM_CH match no channel and are silently dropped.
    assign wr_dec[gi] = bus.cfg_wr && (bus.cfg_ch == 4'(gi));

    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_HP (DEF_HP)
    ) u_chan (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .adv      (adv_w[gi]),
      .sync_rst (bus.sync_rst),
      .wr       (wr_dec[gi]),
      .hp       (bus.cfg_hp),
      .clk_out  (clk_w[gi]),
      .rise     (rise_w[gi]),
      .pending  (pend_w[gi])
    );
  end

  assign bus.clk_out     = clk_w;
  assign bus.rise        = rise_w;
  assign bus.cfg_pending = pend_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboarded bench for clk_div_bank: a period-position model predicts every output per cycle,
// plus directed checks on reset, cascade period/lag and asynchronous reset.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int DEF_HP = 1;

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pend;
  } exp_t;

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DEF_HP (DEF_HP)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   r1_t[$];
  logic prev_rise0 = 1'b0;

  // Model state: position within the full period rather than within a half-period.
  int m_hp[NUM_CH];
  int m_pos[NUM_CH];
  int m_pend_hp[NUM_CH];
  bit m_pend_v[NUM_CH];
  bit m_clk[NUM_CH];
  bit m_rise[NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_hp[i] = DEF_HP; m_pos[i] = 0; m_pend_hp[i] = 0;
      m_pend_v[i] = 0;  m_clk[i] = 0; m_rise[i] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit w, input int ch, input int hp);
    bit   old_rise[NUM_CH];
    exp_t e;
    old_rise = m_rise;
    for (int i = 0; i < NUM_CH; i++) begin
      bit adv;
      bit app;
      adv = (i > 0 && bus.cascade[i]) ? old_rise[i-1] : 1'b1;
      app = 1'b0;
      m_rise[i] = 1'b0;
      if (s || m_hp[i] == 0) begin
        m_pos[i] = 0; m_clk[i] = 1'b0; app = m_pend_v[i];
      end else if (adv) begin
        m_pos[i]++;
        if (m_pos[i] == m_hp[i]) begin
          m_clk[i] = 1'b1; m_rise[i] = 1'b1;
        end else if (m_pos[i] == 2 * m_hp[i]) begin
          m_pos[i] = 0; m_clk[i] = 1'b0; app = m_pend_v[i];
        end
      end
      if (app) begin m_hp[i] = m_pend_hp[i]; m_pend_v[i] = 1'b0; end
      if (w && ch == i) begin m_pend_hp[i] = hp; m_pend_v[i] = 1'b1; end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      e.clk[i] = m_clk[i]; e.rise[i] = m_rise[i]; e.pend[i] = m_pend_v[i];
    end
    sb_q.push_back(e);
  endtask

  // Inputs are applied at the falling edge; outputs are compared 1 time unit after the rising edge.
  task automatic cycle(input bit s, input bit w, input int ch, input int hp);
    exp_t e;
    bus.sync_rst = s;
    bus.cfg_wr   = w;
    bus.cfg_ch   = 4'(ch);
    bus.cfg_hp   = 16'(hp);
    model_step(s, w, ch, hp);
    @(posedge sys_clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check("clk_out", bus.clk_out, e.clk);
    check("rise", bus.rise, e.rise);
    check("cfg_pending", bus.cfg_pending, e.pend);
    if (bus.cascade[1] && bus.rise[1]) check("cascade_lag_rise0", prev_rise0, 1'b1);
    if (bus.rise[1]) r1_t.push_back(cyc);
    prev_rise0 = bus.rise[0];
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0);
  endtask

  task automatic cfg_write(input int ch, input int hp);
    $display("[cyc %0d] cfg_write ch=%0d hp=%0d", cyc, ch, hp);
    cycle(1'b0, 1'b1, ch, hp);
  endtask

  initial begin
    bus.sync_rst = 1'b0;
    bus.cascade  = '0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_hp   = '0;
    model_reset();
    #1;
    check("reset_clk_out", bus.clk_out, 0);
    check("reset_rise", bus.rise, 0);
    check("reset_pending", bus.cfg_pending, 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;
    $display("[cyc %0d] reset released, default divide-by-2", cyc);
    idle(10);

    // Retune ch0 to a divide-by-30 while it is running.
    cfg_write(0, int'(half_period(30)));
    idle(100);

    // Cascade: ch1 counts ch0 rises; sync_rst applies both pendings at once.
    cfg_write(0, int'(half_period(512)));
    cfg_write(1, 15);
    bus.cascade = 4'b0010;
    $display("[cyc %0d] sync_rst with cascade[1]=1", cyc);
    cycle(1'b1, 1'b0, 0, 0);
    r1_t.delete();
    idle(23000);
    check("ch1_rise_count", r1_t.size(), 2);
    if (r1_t.size() >= 2) check("ch1_period", r1_t[1] - r1_t[0], 15360);

    bus.cascade = '0;
    cfg_write(0, 1);
    cfg_write(1, 20);
    cfg_write(3, 20);
    idle(600);

    // Switch ch2 off, then back on at hp=3.
    cfg_write(2, 0);
    idle(20);
    check("ch2_off_clk", bus.clk_out[2], 1'b0);
    cfg_write(2, 3);
    idle(30);

    // Double write to ch3 just after a rise, plus an out-of-range write.
    for (int k = 0; k < 100 && !bus.rise[3]; k++) idle(1);
    check("ch3_rise_seen", bus.rise[3], 1'b1);
    cfg_write(3, 5);
    cfg_write(3, 7);
    cfg_write(NUM_CH, 9);
    check("ch3_pending_held", bus.cfg_pending, 4'b1000);
    idle(100);

    // sync_rst mid-period with ch1 pending and a simultaneous write to ch2.
    idle(7);
    cfg_write(1, 4);
    $display("[cyc %0d] sync_rst with cfg_write ch=2 hp=6", cyc);
    cycle(1'b1, 1'b1, 2, 6);
    check("sync_pending", bus.cfg_pending, 4'b0100);
    idle(60);

    // Asynchronous reset in the middle of a low clock phase.
    idle(3);
    #2;
    reset = 1'b0;
    #1;
    $display("[cyc %0d] async reset asserted", cyc);
    check("areset_clk_out", bus.clk_out, 0);
    check("areset_rise", bus.rise, 0);
    check("areset_pending", bus.cfg_pending, 0);
    model_reset();
    @(posedge sys_clk);
    #1;
    check("areset_hold_clk_out", bus.clk_out, 0);
    @(negedge sys_clk);
    reset = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
